// File: rtl/sdram_burst_tester_if.sv
// Avalon-MM burst bus between the SDRAM self-test master and the controller slave port.
// Handshake: a request (m_read/m_write) completes on any rising edge where it is high
// and m_waitrequest is low; m_readdatavalid marks one returned read beat per cycle.
interface sdram_burst_tester_if #(
    parameter int ADDR_W = 23
);
    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_address;
    logic [15:0]       m_writedata;
    logic [8:0]        m_burstcount;
    logic [1:0]        m_byteenable;
    logic              m_waitrequest;
    logic              m_readdatavalid;
    logic [15:0]       m_readdata;

    modport master (
        output m_read, m_write, m_address, m_writedata, m_burstcount, m_byteenable,
        input  m_waitrequest, m_readdatavalid, m_readdata
    );

    modport slave (
        input  m_read, m_write, m_address, m_writedata, m_burstcount, m_byteenable,
        output m_waitrequest, m_readdatavalid, m_readdata
    );
endinterface

// File: rtl/sdram_burst_tester.sv
// SDRAM self-test master: writes NUM_BURSTS bursts of LFSR data from BASE_ADDR,
// reads the region back, counts miscompares and records the first failing word address.
// A watchdog aborts the pass if the slave stops answering for TIMEOUT cycles.
module sdram_burst_tester #(
    parameter int                ADDR_W     = 23,
    parameter int                BURST      = 8,
    parameter int                NUM_BURSTS = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [15:0]       SEED       = 16'hACE1,
    parameter int                TIMEOUT    = 65535
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    sdram_burst_tester_if.master       bus,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout,
    output logic [15:0]                err_count,
    output logic [ADDR_W-1:0]          first_err_addr,
    output logic [7:0]                 led,
    output logic [2:0]                 dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_CMD  = 3'd2,
        S_RD_DATA = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [15:0]       r_lfsr;
    logic [8:0]        r_beat;
    logic [15:0]       r_burst;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdog;
    logic              r_timeout;
    logic [15:0]       r_err;
    logic [ADDR_W-1:0] r_first;

    logic              w_start_ok;
    logic              w_last_beat;
    logic              w_last_burst;
    logic              w_wr_acc;
    logic              w_cmd_acc;
    logic              w_rd_beat;
    logic              w_activity;
    logic              w_active;
    logic              w_wdog_fire;
    logic              w_mismatch;
    logic [15:0]       w_lfsr_next;
    logic              w_m_read;
    logic              w_m_write;

    assign w_start_ok   = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last_beat  = (r_beat == 9'(BURST - 1));
    assign w_last_burst = (r_burst == 16'(NUM_BURSTS - 1));
    assign w_wr_acc     = (r_state == S_WR) && !bus.m_waitrequest;
    assign w_cmd_acc    = (r_state == S_RD_CMD) && !bus.m_waitrequest;
    // A beat landing in the same cycle the read command is accepted still belongs to this burst.
    assign w_rd_beat    = bus.m_readdatavalid && (r_state == S_RD_DATA || w_cmd_acc);
    assign w_activity   = w_wr_acc || w_cmd_acc || w_rd_beat;
    assign w_active     = (r_state == S_WR) || (r_state == S_RD_CMD) || (r_state == S_RD_DATA);
    assign w_wdog_fire  = w_active && !w_activity && (r_wdog == 32'(TIMEOUT - 1));
    assign w_mismatch   = w_rd_beat && (bus.m_readdata != r_lfsr);
    assign w_lfsr_next  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state and bus request decode.
    always_comb begin
        w_state_next = r_state;
        w_m_read     = 1'b0;
        w_m_write    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_next = S_WR;
            end
            S_WR: begin
                w_m_write = 1'b1;
                if (w_wdog_fire)                                  w_state_next = S_DONE;
                else if (w_wr_acc && w_last_beat && w_last_burst) w_state_next = S_RD_CMD;
            end
            S_RD_CMD: begin
                w_m_read = 1'b1;
                if (w_wdog_fire) w_state_next = S_DONE;
                else if (w_cmd_acc) begin
                    if (w_rd_beat && w_last_beat) w_state_next = w_last_burst ? S_DONE : S_RD_CMD;
                    else                          w_state_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (w_wdog_fire)                   w_state_next = S_DONE;
                else if (w_rd_beat && w_last_beat) w_state_next = w_last_burst ? S_DONE : S_RD_CMD;
            end
            S_DONE: begin
                if (w_start_ok) w_state_next = S_WR;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: LFSR, beat/burst counters, address, watchdog and error bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr    <= SEED;
            r_beat    <= '0;
            r_burst   <= '0;
            r_addr    <= '0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
            r_err     <= '0;
            r_first   <= '0;
        end else if (w_start_ok) begin
            r_lfsr    <= SEED;
            r_beat    <= '0;
            r_burst   <= '0;
            r_addr    <= BASE_ADDR;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
            r_err     <= '0;
            r_first   <= '0;
        end else begin
            if (w_activity || !w_active) r_wdog <= '0;
            else                         r_wdog <= r_wdog + 32'd1;
            if (w_wdog_fire) r_timeout <= 1'b1;

            if (w_wr_acc) begin
                if (w_last_beat) begin
                    r_beat <= '0;
                    if (w_last_burst) begin
                        // Rewind so the read-back regenerates the written sequence.
                        r_burst <= '0;
                        r_addr  <= BASE_ADDR;
                        r_lfsr  <= SEED;
                    end else begin
                        r_burst <= r_burst + 16'd1;
                        r_addr  <= r_addr + ADDR_W'(BURST);
                        r_lfsr  <= w_lfsr_next;
                    end
                end else begin
                    r_beat <= r_beat + 9'd1;
                    r_lfsr <= w_lfsr_next;
                end
            end

            if (w_rd_beat) begin
                r_lfsr <= w_lfsr_next;
                if (w_mismatch) begin
                    if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
                    if (r_err == 16'd0)    r_first <= r_addr + ADDR_W'(r_beat);
                end
                if (w_last_beat) begin
                    r_beat  <= '0;
                    r_burst <= r_burst + 16'd1;
                    r_addr  <= r_addr + ADDR_W'(BURST);
                end else begin
                    r_beat <= r_beat + 9'd1;
                end
            end
        end
    end

    assign bus.m_read       = w_m_read;
    assign bus.m_write      = w_m_write;
    assign bus.m_address    = r_addr;
    assign bus.m_writedata  = (r_state == S_WR) ? r_lfsr : 16'd0;
    assign bus.m_burstcount = 9'(BURST);
    assign bus.m_byteenable = 2'b11;

    assign busy           = w_active;
    assign done           = (r_state == S_DONE);
    assign pass           = done && (r_err == 16'd0) && !r_timeout;
    assign timeout        = r_timeout;
    assign err_count      = r_err;
    assign first_err_addr = r_first;
    assign led            = {done, pass, r_timeout, r_err[4:0]};
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_sdram_burst_tester.sv
// Bench for sdram_burst_tester: behavioural Avalon slave with memory, stall, corrupt and
// drop-beat modes; write/read-command scoreboards; table of end-of-pass results.
module tb_sdram_burst_tester;

    localparam int          AW   = 23;
    localparam int          BL   = 8;
    localparam int          NB   = 4;
    localparam int          TO   = 100;
    localparam logic [22:0] BASE = 23'h7FFFF8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sb_clear = 1'b0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [22:0] first_err_addr;
    logic [7:0]  led;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_miss = 0;

    sdram_burst_tester_if #(.ADDR_W(AW)) bus ();

    sdram_burst_tester #(
        .ADDR_W(AW), .BURST(BL), .NUM_BURSTS(NB), .BASE_ADDR(BASE), .SEED(SEED), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(rst_n), .start(start), .bus(bus),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_addr(first_err_addr), .led(led), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [38:0] exp_q[$];     // {beat address, write data}
    logic [22:0] rd_exp_q[$];  // expected read burst start addresses

    typedef struct {
        int          due;
        logic [22:0] addr;
    } rd_t;
    rd_t rq[$];

    logic        stall_mode = 1'b0;
    logic        corrupt_mode = 1'b0;
    logic        drop_mode = 1'b0;
    logic [2:0]  stall_cnt = 3'd0;
    logic [15:0] mem [logic [22:0]];
    int          cyc = 0;
    int          wbeat = 0;
    int          rd_idx = 0;
    int          wr_cnt = 0;
    int          last_rv_cyc = 0;

    assign bus.m_waitrequest = stall_mode && (stall_cnt != 3'd5);

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    initial begin : slave
        logic [22:0] a;
        logic [38:0] e;
        logic [22:0] ea;
        logic [15:0] d;
        logic        rv;
        logic        prev_stall;
        logic [22:0] prev_addr;
        logic [15:0] prev_wd;
        rd_t         r;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_wd    = '0;
        bus.m_readdatavalid = 1'b0;
        bus.m_readdata      = 16'd0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n || sb_clear) begin
                wbeat = 0; rd_idx = 0; wr_cnt = 0; rq.delete(); prev_stall = 1'b0;
                stall_cnt <= 3'd0;
                bus.m_readdatavalid <= 1'b0;
                bus.m_readdata      <= 16'd0;
            end else begin
                if (bus.m_read || bus.m_write)
                    check("rw_exclusive", 64'(bus.m_read & bus.m_write), 64'd0);
                if (bus.m_read || bus.m_write)
                    stall_cnt <= (stall_cnt == 3'd5) ? 3'd0 : stall_cnt + 3'd1;
                else
                    stall_cnt <= 3'd0;

                if (bus.m_write && bus.m_waitrequest) begin
                    if (prev_stall) begin
                        check("stall_addr_hold", 64'(bus.m_address), 64'(prev_addr));
                        check("stall_wdata_hold", 64'(bus.m_writedata), 64'(prev_wd));
                    end
                    prev_stall = 1'b1;
                    prev_addr  = bus.m_address;
                    prev_wd    = bus.m_writedata;
                end else begin
                    prev_stall = 1'b0;
                end

                if (bus.m_write && !bus.m_waitrequest) begin
                    a = bus.m_address + 23'(wbeat);
                    mem[a] = bus.m_writedata;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'(a), 64'h7FFFFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_beat_addr", 64'(a), 64'(e[38:16]));
                        check("wr_beat_data", 64'(bus.m_writedata), 64'(e[15:0]));
                    end
                    wbeat = (wbeat == BL - 1) ? 0 : wbeat + 1;
                    wr_cnt++;
                end

                if (bus.m_read && !bus.m_waitrequest) begin
                    if (rd_exp_q.size() == 0) begin
                        check("unexpected_rd_cmd", 64'(bus.m_address), 64'h7FFFFFFF);
                    end else begin
                        ea = rd_exp_q.pop_front();
                        check("rd_cmd_addr", 64'(bus.m_address), 64'(ea));
                    end
                    for (int k = 0; k < BL; k++) begin
                        r.due  = cyc + 2 + k;
                        r.addr = bus.m_address + 23'(k);
                        rq.push_back(r);
                    end
                end

                if (bus.m_readdatavalid) last_rv_cyc = cyc;

                rv = 1'b0;
                d  = 16'd0;
                if (rq.size() > 0 && rq[0].due <= cyc) begin
                    r = rq.pop_front();
                    d = mem.exists(r.addr) ? mem[r.addr] : 16'hDEAD;
                    if (corrupt_mode && (rd_idx == 10 || rd_idx == 20)) d[0] = ~d[0];
                    if (!(drop_mode && rd_idx == 7)) rv = 1'b1;
                    rd_idx++;
                end
                bus.m_readdatavalid <= rv;
                bus.m_readdata      <= d;
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic        stall;
        logic        corrupt;
        logic        drop;
        logic        mid_start;
        logic        exp_pass;
        logic        exp_timeout;
        logic [15:0] exp_err;
        logic [22:0] exp_first;
        logic [7:0]  exp_led;
        int          exp_rd_left;
    } vec_t;
    vec_t vt[5];

    task automatic load_expectations();
        logic [15:0] q;
        exp_q.delete();
        rd_exp_q.delete();
        q = SEED;
        for (int b = 0; b < NB; b++) begin
            rd_exp_q.push_back(BASE + 23'(b * BL));
            for (int k = 0; k < BL; k++) begin
                exp_q.push_back({BASE + 23'(b * BL + k), q});
                q = lfsr_next(q);
            end
        end
    endtask

    task automatic pulse_start(input logic clear_sb);
        start = 1'b1;
        sb_clear = clear_sb;
        @(negedge clk);
        start = 1'b0;
        sb_clear = 1'b0;
    endtask

    task automatic run_vec(input int i);
        int waited;
        @(negedge clk);
        stall_mode   = vt[i].stall;
        corrupt_mode = vt[i].corrupt;
        drop_mode    = vt[i].drop;
        load_expectations();
        pulse_start(1'b1);
        check({vt[i].name, ".busy_after_start"}, 64'(busy), 64'd1);
        check({vt[i].name, ".done_after_start"}, 64'(done), 64'd0);
        if (vt[i].mid_start) begin
            repeat (10) @(negedge clk);
            check({vt[i].name, ".state_before_restart"}, 64'(dbg_state), 64'd1);
            pulse_start(1'b0);
        end
        waited = 0;
        while (!done && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check({vt[i].name, ".done"}, 64'(done), 64'd1);
        check({vt[i].name, ".busy"}, 64'(busy), 64'd0);
        check({vt[i].name, ".pass"}, 64'(pass), 64'(vt[i].exp_pass));
        check({vt[i].name, ".timeout"}, 64'(timeout), 64'(vt[i].exp_timeout));
        check({vt[i].name, ".err_count"}, 64'(err_count), 64'(vt[i].exp_err));
        check({vt[i].name, ".first_err_addr"}, 64'(first_err_addr), 64'(vt[i].exp_first));
        check({vt[i].name, ".led"}, 64'(led), 64'(vt[i].exp_led));
        check({vt[i].name, ".m_read_idle"}, 64'(bus.m_read), 64'd0);
        check({vt[i].name, ".m_write_idle"}, 64'(bus.m_write), 64'd0);
        check({vt[i].name, ".writes_left"}, 64'(exp_q.size()), 64'd0);
        check({vt[i].name, ".rd_cmds_left"}, 64'(rd_exp_q.size()), 64'(vt[i].exp_rd_left));
        if (vt[i].exp_timeout)
            check({vt[i].name, ".timeout_latency_ok"},
                  64'((cyc - last_rv_cyc) >= 95 && (cyc - last_rv_cyc) <= 105), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int waited;
        vt[0] = '{"ideal",    0, 0, 0, 0, 1, 0, 16'd0, 23'h000000, 8'hC0, 0};
        vt[1] = '{"stalled",  1, 0, 0, 0, 1, 0, 16'd0, 23'h000000, 8'hC0, 0};
        vt[2] = '{"corrupt",  0, 1, 0, 0, 0, 0, 16'd2, 23'h000002, 8'h82, 0};
        vt[3] = '{"drop",     0, 0, 1, 0, 0, 1, 16'd0, 23'h000000, 8'hA0, 3};
        vt[4] = '{"midstart", 0, 0, 0, 1, 1, 0, 16'd0, 23'h000000, 8'hC0, 0};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst.m_read", 64'(bus.m_read), 64'd0);
        check("rst.m_write", 64'(bus.m_write), 64'd0);
        check("rst.m_address", 64'(bus.m_address), 64'd0);
        check("rst.m_writedata", 64'(bus.m_writedata), 64'd0);
        check("rst.m_burstcount", 64'(bus.m_burstcount), 64'd8);
        check("rst.m_byteenable", 64'(bus.m_byteenable), 64'd3);
        check("rst.outputs", 64'({busy, done, pass, timeout}), 64'd0);
        check("rst.err_count", 64'(err_count), 64'd0);
        check("rst.first_err_addr", 64'(first_err_addr), 64'd0);
        check("rst.led", 64'(led), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.state_idle", 64'(dbg_state), 64'd0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Reset asserted while write beat 3 is on the bus.
        @(negedge clk);
        stall_mode = 1'b0; corrupt_mode = 1'b0; drop_mode = 1'b0;
        load_expectations();
        pulse_start(1'b1);
        waited = 0;
        while (wr_cnt < 3 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("midrst.reached_beat3", 64'(wr_cnt), 64'd3);
        check("midrst.write_active", 64'(bus.m_write), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.m_write_async", 64'(bus.m_write), 64'd0);
        check("midrst.state_idle", 64'(dbg_state), 64'd0);
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.err_count", 64'(err_count), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst.idle_after_release", 64'(dbg_state), 64'd0);
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sdram_burst_tester.md
Name: sdram_burst_tester

Overview:
- Avalon-MM burst master that drives the team's SDRAM controller slave port from the initiator side.
- Writes NUM_BURSTS bursts of LFSR pseudo-random data starting at BASE_ADDR, then reads the same region back and compares every beat.
- Reports pass/fail, error count and first failing address, and mirrors status on the board LEDs.
- Serves as the board-level self-test and bring-up master for the SDRAM subsystem.

Parameters:
- ADDR_W, 23, width of the word address into the controller.
- BURST, 8, beats per burst; legal values 1, 2, 4, 8, 256.
- NUM_BURSTS, 16, bursts per pass (1..65535).
- BASE_ADDR, 0, first word address.
- SEED, 16'hACE1, LFSR seed; must be nonzero.
- TIMEOUT, 65535, maximum idle cycles while waiting for a handshake or read beat.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a test pass.
- m_read  out  1  Avalon read request.
- m_write  out  1  Avalon write request.
- m_address  out  ADDR_W  burst start word address.
- m_writedata  out  16  write beat data.
- m_burstcount  out  9  burst length; constant BURST.
- m_byteenable  out  2  constant 2'b11.
- m_waitrequest  in  1  slave stall.
- m_readdatavalid  in  1  read beat strobe.
- m_readdata  in  16  read beat data.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  high in DONE; held until the next start.
- pass  out  1  valid when done: err_count==0 and no timeout.
- timeout  out  1  a watchdog expiry occurred.
- err_count  out  16  miscompare count; saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  word address of the first miscompare.
- led  out  8  {done, pass, timeout, err_count[4:0]}.

Behaviour:
- Reset (asserted asynchronously, released synchronously) clears all outputs and internal state to 0, except m_byteenable=2'b11 and m_burstcount=BURST. State returns to IDLE; the LFSR loads SEED. Reset mid-burst drops m_read/m_write immediately and performs no bus cleanup.
- LFSR update: next = {q[14:0], q[15]^q[13]^q[12]^q[10]}. It advances once per accepted write beat and once per received read beat. It reloads SEED on entering WR and again on entering RD_CMD, so the read-back sequence equals the write sequence.
- Beat address: beat k of burst b is at BASE_ADDR + b*BURST + k, computed modulo 2^ADDR_W. Wrap past the top of memory is legal and silent.
- IDLE: masters idle. On start, clear err_count, timeout and first_err_addr, reload the LFSR, set busy=1 and done=0, then go to WR. A start pulse in any other state except DONE is ignored.
- WR: m_write=1, m_address=burst start, m_writedata=LFSR value.
  - A beat is accepted when m_write && !m_waitrequest; then advance the LFSR and the beat counter.
  - m_address and m_writedata hold stable while m_waitrequest=1.
  - After beat BURST-1 of the last burst: drop m_write and go to RD_CMD.
  - Between bursts m_write stays high; the next burst's address is presented in the cycle after the last beat is accepted.
- RD_CMD: m_read=1 with the burst start address. The command is accepted when m_read && !m_waitrequest; then drop m_read and go to RD_DATA.
- RD_DATA: each m_readdatavalid compares m_readdata with the LFSR value, then advances the LFSR.
  - A read beat arriving in RD_CMD in the same cycle as acceptance is also counted.
  - On mismatch: err_count++ (saturating). If this is the first error, record first_err_addr as the beat address.
  - After BURST beats: go to RD_CMD for the next burst, or to DONE after the last burst.
  - m_readdatavalid in IDLE, WR or DONE is ignored.
- Watchdog: a counter resets on every handshake or read beat and increments otherwise in WR, RD_CMD and RD_DATA. When it reaches TIMEOUT: set timeout=1, drop m_read/m_write and go to DONE.
- DONE: busy=0, done=1, pass=(err_count==0 && !timeout). On start, re-enter via the IDLE start actions within the same cycle.
- m_read and m_write are never both high.

Test Plan:
- Ideal slave model (waitrequest=0, read latency 3), BURST=8, NUM_BURSTS=4, start -> 32 writes with LFSR sequence from 16'hACE1; done=1, pass=1, err_count=0, led=8'b1100_0000.
- Slave holding waitrequest=1 for 5 cycles per beat -> m_address and m_writedata stable while stalled; results identical to the first case.
- Slave corrupts read beat 10 (bit 0 flipped) and beat 20 -> err_count=2; first_err_addr=BASE_ADDR+10; pass=0.
- BASE_ADDR=23'h7FFFF8, BURST=8, NUM_BURSTS=2 -> second burst address 23'h000000; pass=1.
- Slave returns only 7 of 8 read beats, TIMEOUT=100 -> timeout=1 about 100 cycles after the last beat; done=1, pass=0, m_read=0.
- Reset asserted during WR beat 3 -> m_write=0 asynchronously, state IDLE, err_count=0; a new start then completes with pass=1.
